// File: rtl/rotate_nco.sv
// Complex phase rotator with built-in NCO: out = in * e^{j*theta}.
// Six-stage pipeline around an external synchronous octant sin/cos LUT.
module rotate_nco #(
  parameter int DATA_WIDTH      = 16,
  parameter int PHASE_WIDTH     = 16,
  parameter int LUT_LEN_SHIFT   = 11,
  parameter int LUT_WIDTH       = 16,
  parameter int LUT_SCALE_SHIFT = 14
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            mode,
  input  logic signed [PHASE_WIDTH-1:0]   freq,
  input  logic                            acc_clear,
  input  logic signed [DATA_WIDTH-1:0]    in_i,
  input  logic signed [DATA_WIDTH-1:0]    in_q,
  input  logic signed [PHASE_WIDTH-1:0]   phase,
  input  logic                            input_strobe,
  output logic [LUT_LEN_SHIFT:0]          rot_addr,
  input  logic [2*LUT_WIDTH-1:0]          rot_data,
  output logic signed [DATA_WIDTH-1:0]    out_i,
  output logic signed [DATA_WIDTH-1:0]    out_q,
  output logic                            output_strobe,
  output logic                            sat
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = PHASE_WIDTH;
  localparam int LW = LUT_WIDTH;
  localparam int OW = PW - 3;
  localparam int AS = OW - LUT_LEN_SHIFT;
  localparam int CW = LW + 1;
  localparam int MW = DW + CW;
  localparam int SW = MW + 1;

  localparam logic [OW:0] OCT = {1'b1, {OW{1'b0}}};
  localparam logic signed [SW-1:0] HALF =
    {{(SW-LUT_SCALE_SHIFT){1'b0}}, 1'b1, {(LUT_SCALE_SHIFT-1){1'b0}}};
  localparam logic signed [SW-1:0] MAXV =
    {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV =
    {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [PW-1:0] acc;
  logic signed [PW-1:0] theta;

  logic signed [DW-1:0] s0_i, s0_q;
  logic signed [PW-1:0] s0_th;
  logic                 s0_v;

  logic [2:0]           s1_k;
  logic signed [DW-1:0] s1_i, s1_q;
  logic                 s1_v;

  logic [2:0]           s2_k;
  logic signed [DW-1:0] s2_i, s2_q;
  logic                 s2_v;

  logic                 en_q;
  logic [2*LW-1:0]      rot_hold;

  logic signed [CW-1:0] s3_c, s3_s;
  logic signed [DW-1:0] s3_i, s3_q;
  logic                 s3_v;

  logic signed [MW-1:0] s4_ic, s4_qs, s4_is, s4_qc;
  logic                 s4_v;

  assign theta = phase + (mode ? acc : '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
    end else if (enable) begin
      if (acc_clear)
        acc <= '0;
      else if (input_strobe)
        acc <= acc + freq;
    end
  end

  logic [2:0]    k0;
  logic [OW-1:0] r0;
  logic [OW:0]   a0;

  always_comb begin
    k0 = s0_th[PW-1:PW-3];
    r0 = s0_th[OW-1:0];
    a0 = k0[0] ? (OCT - {1'b0, r0}) : {1'b0, r0};
  end

  // The LUT re-reads the held rot_addr every cycle, so the word that
  // belongs to stage 2 is captured on the first stalled edge.
  logic [2*LW-1:0]      lut;
  logic signed [LW-1:0] lut_c, lut_s;
  logic signed [CW-1:0] ce, se, cn, sn, cs_c, cs_s;

  always_comb begin
    lut   = en_q ? rot_data : rot_hold;
    lut_c = lut[2*LW-1:LW];
    lut_s = lut[LW-1:0];
    ce    = {lut_c[LW-1], lut_c};
    se    = {lut_s[LW-1], lut_s};
    cn    = -ce;
    sn    = -se;
    cs_c  = ce;
    cs_s  = se;
    unique case (s2_k)
      3'd0: begin cs_c = ce; cs_s = se; end
      3'd1: begin cs_c = se; cs_s = ce; end
      3'd2: begin cs_c = sn; cs_s = ce; end
      3'd3: begin cs_c = cn; cs_s = se; end
      3'd4: begin cs_c = cn; cs_s = sn; end
      3'd5: begin cs_c = sn; cs_s = cn; end
      3'd6: begin cs_c = se; cs_s = cn; end
      3'd7: begin cs_c = ce; cs_s = sn; end
    endcase
  end

  logic signed [SW-1:0] pi, pq, sh_i, sh_q;
  logic signed [DW-1:0] y_i, y_q;
  logic                 clip_i, clip_q;

  always_comb begin
    pi     = SW'(s4_ic) - SW'(s4_qs);
    pq     = SW'(s4_is) + SW'(s4_qc);
    sh_i   = (pi + HALF) >>> LUT_SCALE_SHIFT;
    sh_q   = (pq + HALF) >>> LUT_SCALE_SHIFT;
    clip_i = (sh_i > MAXV) || (sh_i < MINV);
    clip_q = (sh_q > MAXV) || (sh_q < MINV);
    y_i    = sh_i[DW-1:0];
    y_q    = sh_q[DW-1:0];
    if (sh_i > MAXV) y_i = MAXV[DW-1:0];
    if (sh_i < MINV) y_i = MINV[DW-1:0];
    if (sh_q > MAXV) y_q = MAXV[DW-1:0];
    if (sh_q < MINV) y_q = MINV[DW-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      en_q     <= 1'b0;
      rot_hold <= '0;
    end else begin
      en_q <= enable;
      if (!enable && en_q)
        rot_hold <= rot_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s0_i <= '0; s0_q <= '0; s0_th <= '0; s0_v <= 1'b0;
      s1_i <= '0; s1_q <= '0; s1_k <= '0; s1_v <= 1'b0;
      rot_addr <= '0;
      s2_i <= '0; s2_q <= '0; s2_k <= '0; s2_v <= 1'b0;
      s3_i <= '0; s3_q <= '0; s3_c <= '0; s3_s <= '0;
      s3_v <= 1'b0;
      s4_ic <= '0; s4_qs <= '0; s4_is <= '0; s4_qc <= '0;
      s4_v <= 1'b0;
      out_i <= '0; out_q <= '0;
      output_strobe <= 1'b0; sat <= 1'b0;
    end else if (enable) begin
      s0_i  <= in_i;
      s0_q  <= in_q;
      s0_th <= theta;
      s0_v  <= input_strobe;

      s1_i     <= s0_i;
      s1_q     <= s0_q;
      s1_k     <= k0;
      s1_v     <= s0_v;
      rot_addr <= a0[OW:AS];

      s2_i <= s1_i;
      s2_q <= s1_q;
      s2_k <= s1_k;
      s2_v <= s1_v;

      s3_i <= s2_i;
      s3_q <= s2_q;
      s3_c <= cs_c;
      s3_s <= cs_s;
      s3_v <= s2_v;

      s4_ic <= MW'(s3_i) * MW'(s3_c);
      s4_qs <= MW'(s3_q) * MW'(s3_s);
      s4_is <= MW'(s3_i) * MW'(s3_s);
      s4_qc <= MW'(s3_q) * MW'(s3_c);
      s4_v  <= s3_v;

      output_strobe <= s4_v;
      sat           <= s4_v & (clip_i | clip_q);
      if (s4_v) begin
        out_i <= y_i;
        out_q <= y_q;
      end
    end
  end

endmodule

// File: doc/rotate_nco.md
Name: rotate_nco

Overview:
- Parametrised complex phase rotator with a built-in numerically controlled oscillator (NCO). It computes out = in · e^{jθ}.
- θ comes from one of two sources:
  - MODE_FIXED: a per-sample phase input.
  - MODE_NCO: an internal phase accumulator stepped by a frequency word, plus the per-sample phase offset.
- It sits in the OFDM receive chain for CFO correction and uses an external synchronous octant sin/cos LUT.
- It applies explicit rounding and saturation on the output.

Parameters:
- DATA_WIDTH, 16, width of the in/out I and Q samples (signed).
- PHASE_WIDTH, 16, binary-angle width; the full circle is 2^PHASE_WIDTH and the value is two's complement in [-π, π). Must be ≥ LUT_LEN_SHIFT+3.
- LUT_LEN_SHIFT, 11, the LUT covers [0, π/4] with 2^LUT_LEN_SHIFT+1 entries.
- LUT_WIDTH, 16, width of each signed cos/sin entry.
- LUT_SCALE_SHIFT, 14, entry scale: cos(0) = 2^LUT_SCALE_SHIFT.

Ports:
- clock, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- enable, in, 1, pipeline advance; when low, every register holds.
- mode, in, 1, 0 = fixed phase, 1 = NCO.
- freq, in, PHASE_WIDTH, signed phase step per strobe (NCO mode).
- acc_clear, in, 1, zeroes the accumulator.
- in_i / in_q, in, DATA_WIDTH each, signed sample.
- phase, in, PHASE_WIDTH, signed phase or offset.
- input_strobe, in, 1, sample valid.
- rot_addr, out, LUT_LEN_SHIFT+1, LUT address.
- rot_data, in, 2·LUT_WIDTH, {cos, sin}; valid one cycle after rot_addr.
- out_i / out_q, out, DATA_WIDTH each, signed result.
- output_strobe, out, 1, result valid.
- sat, out, 1, pulses with output_strobe if either component was clipped.

Behaviour:
- Reset values:
  - Cleared to 0: all pipeline registers, acc, rot_addr, out_i, out_q, output_strobe and sat.
  - Reset mid-stream discards every in-flight sample; no strobe emerges afterwards.
- Latency and flow:
  - Fixed latency of 6 enabled cycles: a sample strobed in enabled cycle n yields output_strobe in enabled cycle n+6.
  - Strobes may be back-to-back or gapped.
  - The valid bit travels with its data; non-strobe cycles still advance the pipeline.
- enable low:
  - Freezes all stages, acc and the outputs.
  - output_strobe holds its value and is not re-counted.
  - rot_addr holds, so the LUT data stays consistent.
- Accumulator, updated only on enabled cycles with a strobe:
  - θ = phase + (mode ? acc : 0), wrapping modulo 2^PHASE_WIDTH.
  - Then acc <= acc + freq, also wrapping.
  - The first sample after a clear uses acc = 0.
  - acc_clear takes priority over the increment; that cycle's sample still uses the pre-clear acc.
  - In mode 0, acc keeps accumulating.
- S0: register in_i, in_q, θ and valid.
- S1, octant fold:
  - u = θ as unsigned.
  - k = u[PW-1:PW-3].
  - r = u[PW-4:0].
  - a = r for even k; a = 2^(PW-3) − r for odd k.
  - rot_addr <= a >> (PW-3-LUT_LEN_SHIFT), truncated. The maximum value 2^LUT_LEN_SHIFT (π/4) is legal.
  - k and the data are delayed alongside.
- S2: LUT access; c = rot_data[2W-1:W], s = rot_data[W-1:0].
- S3: register (c', s') by k:
  - 0: (c, s)
  - 1: (s, c)
  - 2: (−s, c)
  - 3: (−c, s)
  - 4: (−c, −s)
  - 5: (−s, −c)
  - 6: (s, −c)
  - 7: (c, −s)
  - Negation is full precision, one extra bit, with no overflow.
- S4: register the four full-width products i·c', q·s', i·s' and q·c'.
- S5:
  - pi = i·c' − q·s'; pq = i·s' + q·c', each with one guard bit.
  - Round half-up: add 2^(LUT_SCALE_SHIFT−1), then arithmetic shift right by LUT_SCALE_SHIFT.
  - Saturate to [−2^(DW−1), 2^(DW−1)−1].
  - Register out_i, out_q, sat and output_strobe.
- Phase boundaries: θ = −2^(PW−1) (−π) is octant 4 with a = 0. Exact octant edges use a = 0 or a = π/4.

Test Plan:
- Mode 0:
  - phase=0, in=(1000,0) → out=(1000,0), 6 cycles later, sat=0.
  - phase=16384 (π/2), in=(1000,0) → rot_addr=0, out=(0,1000).
  - phase=−32768 (−π), in=(1000,0) → out=(−1000,0).
  - phase=−16384 → out=(0,−1000).
- Mode 1, acc_clear then freq=16384, phase=0, four back-to-back strobes of (1000,0) → outputs (1000,0), (0,1000), (−1000,0), (0,−1000); acc wraps to 0 after the fourth.
- Saturation, using a behavioural ROM with entry value round(2^14·cos/sin):
  - in=(32767,32767), phase=8192 (π/4), cos=sin=11585 → out_i=0, out_q=32767, sat=1.
  - in=(−32768,−32768), phase=8192 → out_i=0, out_q=−32768, sat=1.
- enable low for 3 cycles mid-burst → outputs, order and values are identical to the unstalled run; output_strobe count equals input_strobe count.
- reset asserted while 3 samples are in flight → next cycle all outputs are 0; no strobe appears; acc=0, so the next NCO sample uses acc=0.
